// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter: grants one requester at a time a burst of up to
// BURST_LEN words into a single FIFO write port.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no grant held; picks next requester round-robin if any valid
// ST_BURST | grant held; words move while valid and FIFO not full
module fifo_write_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int BURST_LEN  = 16
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [NUM_REQ-1:0]            valid_in,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
   output logic [NUM_REQ-1:0]            ready_out,
   output logic [DATA_WIDTH-1:0]         fifo_data,
   output logic                          fifo_req,
   input  logic                          fifo_full,
   output logic [2:0]                    grant_id,
   output logic                          busy
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   localparam logic [2:0] LAST_GRANT_RST = 3'(NUM_REQ - 1);
   localparam logic [7:0] COUNT_TC       = 8'(BURST_LEN - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [2:0]            r_grant_id;
   logic [2:0]            w_grant_nxt;
   logic [2:0]            r_last_grant;
   logic [2:0]            w_last_nxt;
   logic [7:0]            r_count;
   logic [7:0]            w_count_nxt;

   logic [2:0]            w_sel;
   logic                  w_sel_found;
   logic                  w_gvalid;
   logic [DATA_WIDTH-1:0] w_gdata;
   logic                  w_busy;
   logic                  w_xfer;
   logic                  w_last_word;

   // Round-robin pick: first valid requester after last_grant, wrapping.
   always_comb begin
      w_sel       = '0;
      w_sel_found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_sel_found && valid_in[i] &&
                ((int'(r_last_grant) + k) % NUM_REQ == i)) begin
               w_sel_found = 1'b1;
               w_sel       = 3'(i);
            end
         end
      end
   end

   always_comb begin
      w_gvalid = 1'b0;
      w_gdata  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_grant_id == 3'(i)) begin
            w_gvalid = valid_in[i];
            w_gdata  = data_in[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_busy      = (r_state == ST_BURST);
   assign w_xfer      = w_busy && w_gvalid && !fifo_full;
   assign w_last_word = (r_count == COUNT_TC);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state      <= ST_IDLE;
         r_grant_id   <= '0;
         r_last_grant <= LAST_GRANT_RST;
         r_count      <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_grant_id   <= w_grant_nxt;
         r_last_grant <= w_last_nxt;
         r_count      <= w_count_nxt;
      end
   end

   // A full FIFO only stalls; a dropped valid ends the burst without a word.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant_id;
      w_last_nxt  = r_last_grant;
      w_count_nxt = r_count;
      case (r_state)
         ST_IDLE: begin
            if (w_sel_found) begin
               w_state_nxt = ST_BURST;
               w_grant_nxt = w_sel;
               w_count_nxt = '0;
            end
         end
         ST_BURST: begin
            if (!w_gvalid) begin
               w_state_nxt = ST_IDLE;
               w_last_nxt  = r_grant_id;
            end else if (w_xfer) begin
               w_count_nxt = r_count + 8'd1;
               if (w_last_word) begin
                  w_state_nxt = ST_IDLE;
                  w_last_nxt  = r_grant_id;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      ready_out = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         ready_out[i] = w_xfer && (r_grant_id == 3'(i));
      end
   end

   assign busy      = w_busy;
   assign grant_id  = r_grant_id;
   assign fifo_req  = w_xfer;
   assign fifo_data = w_busy ? w_gdata : '0;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: a 16-word and a 1-word burst instance share
// stimulus and are compared every cycle against a burst-level reference model.
module tb_fifo_write_arbiter;

   localparam int DW = 8;
   localparam int NR = 4;
   localparam int BL = 16;

   logic          clk = 1'b0;
   logic          resetn;
   logic [NR-1:0] valid_in;
   logic [NR*DW-1:0] data_in;
   logic          fifo_full;

   logic [NR-1:0] ready_a, ready_b;
   logic [DW-1:0] fdata_a, fdata_b;
   logic          freq_a, freq_b;
   logic [2:0]    gid_a, gid_b;
   logic          busy_a, busy_b;

   always #5 clk = ~clk;

   fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(BL)) u_dut (
      .clk(clk), .resetn(resetn), .valid_in(valid_in), .data_in(data_in),
      .ready_out(ready_a), .fifo_data(fdata_a), .fifo_req(freq_a),
      .fifo_full(fifo_full), .grant_id(gid_a), .busy(busy_a)
   );

   fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(1)) u_dut1 (
      .clk(clk), .resetn(resetn), .valid_in(valid_in), .data_in(data_in),
      .ready_out(ready_b), .fifo_data(fdata_b), .fifo_req(freq_b),
      .fifo_full(fifo_full), .grant_id(gid_b), .busy(busy_b)
   );

   // Reference: who holds the grant, how many words moved, who went last.
   typedef struct {
      bit busy;
      int gid;
      int last;
      int cnt;
   } mdl_t;

   typedef struct {
      logic [NR-1:0] v;
      logic          f;
      logic          r;
      logic          e_busy;
      logic          e_req;
      logic [2:0]    e_gid;
      logic [NR-1:0] e_rdy;
   } vec_t;

   mdl_t ma, mb;
   int   n_cmp  = 0;
   int   n_fail = 0;
   bit   chk_en = 1'b0;
   int   cyc    = 0;

   int bg_a[$], bw_a[$], bs_a[$], bc_a[$];
   int bg_b[$], bw_b[$], bs_b[$];
   logic pb_a = 1'b0, pb_b = 1'b0;

   function automatic mdl_t mdl_next(mdl_t m, logic [NR-1:0] v, logic f, logic r, int blen);
      mdl_t n = m;
      if (!r) begin
         n.busy = 1'b0; n.gid = 0; n.last = NR - 1; n.cnt = 0;
      end else if (!m.busy) begin
         for (int k = 1; k <= NR; k++) begin
            if (!n.busy && v[(m.last + k) % NR]) begin
               n.busy = 1'b1; n.gid = (m.last + k) % NR; n.cnt = 0;
            end
         end
      end else if (!v[m.gid]) begin
         n.busy = 1'b0; n.last = m.gid;
      end else if (!f) begin
         n.cnt = m.cnt + 1;
         if (n.cnt == blen) begin
            n.busy = 1'b0; n.last = m.gid;
         end
      end
      return n;
   endfunction

   function automatic int qget(int q[$], int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic check_dut(input string tag, input mdl_t m, input logic b, input logic q,
                            input logic [2:0] g, input logic [NR-1:0] rd, input logic [DW-1:0] fd);
      logic xfer;
      logic [31:0] e_rdy, e_fd;
      xfer  = m.busy && valid_in[m.gid] && !fifo_full;
      e_rdy = xfer ? (32'd1 << m.gid) : 32'd0;
      e_fd  = m.busy ? 32'(data_in[m.gid*DW +: DW]) : 32'd0;
      chk({tag, ".busy"}, 32'(b), 32'(m.busy));
      chk({tag, ".fifo_req"}, 32'(q), 32'(xfer));
      chk({tag, ".ready_out"}, 32'(rd), e_rdy);
      chk({tag, ".fifo_data"}, 32'(fd), e_fd);
      if (m.busy) chk({tag, ".grant_id"}, 32'(g), 32'(m.gid));
   endtask

   task automatic tick(input logic [NR-1:0] v, input logic f, input logic r,
                       output logic [NR-1:0] o_rdy, output logic o_busy,
                       output logic o_req, output logic [2:0] o_gid);
      valid_in  = v;
      fifo_full = f;
      resetn    = r;
      data_in   = $urandom;
      @(negedge clk);
      if (chk_en) begin
         check_dut("A", ma, busy_a, freq_a, gid_a, ready_a, fdata_a);
         check_dut("B", mb, busy_b, freq_b, gid_b, ready_b, fdata_b);
      end
      if (busy_a === 1'b1 && pb_a !== 1'b1) begin
         bg_a.push_back(int'(gid_a)); bw_a.push_back(0);
         bs_a.push_back(cyc); bc_a.push_back(0);
      end
      if (busy_a === 1'b1 && bc_a.size() > 0) bc_a[bc_a.size()-1] = bc_a[bc_a.size()-1] + 1;
      if (freq_a === 1'b1 && bw_a.size() > 0) bw_a[bw_a.size()-1] = bw_a[bw_a.size()-1] + 1;
      if (busy_b === 1'b1 && pb_b !== 1'b1) begin
         bg_b.push_back(int'(gid_b)); bw_b.push_back(0); bs_b.push_back(cyc);
      end
      if (freq_b === 1'b1 && bw_b.size() > 0) bw_b[bw_b.size()-1] = bw_b[bw_b.size()-1] + 1;
      pb_a   = busy_a;
      pb_b   = busy_b;
      o_rdy  = ready_a;
      o_busy = busy_a;
      o_req  = freq_a;
      o_gid  = gid_a;
      @(posedge clk);
      ma = mdl_next(ma, v, f, r, BL);
      mb = mdl_next(mb, v, f, r, 1);
      cyc++;
      #1;
   endtask

   task automatic step(input logic [NR-1:0] v, input logic f, input logic r);
      logic [NR-1:0] d_rdy;
      logic d_b, d_q;
      logic [2:0] d_g;
      tick(v, f, r, d_rdy, d_b, d_q, d_g);
   endtask

   task automatic do_reset();
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      bg_a.delete(); bw_a.delete(); bs_a.delete(); bc_a.delete();
      bg_b.delete(); bw_b.delete(); bs_b.delete();
      cyc = 0;
   endtask

   vec_t tbl[14];
   logic [NR-1:0] o_rdy;
   logic o_b, o_q;
   logic [2:0] o_g;
   int st;

   initial begin
      valid_in = '0; fifo_full = 1'b0; resetn = 1'b0; data_in = '0;
      //           v        f     r     busy  req   gid   ready
      tbl[0]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0000};
      tbl[1]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0000};
      tbl[2]  = '{4'b0100, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 4'b0100};
      tbl[3]  = '{4'b0110, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 4'b0000};
      tbl[4]  = '{4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 4'b0000};
      tbl[5]  = '{4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0000};
      tbl[6]  = '{4'b0011, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 4'b0001};
      tbl[7]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'b0000};
      tbl[8]  = '{4'b1010, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0000};
      tbl[9]  = '{4'b1000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 4'b0000};
      tbl[10] = '{4'b1010, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0000};
      tbl[11] = '{4'b1010, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 4'b1000};
      tbl[12] = '{4'b1010, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 4'b1000};
      tbl[13] = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0000};

      do_reset();
      chk_en = 1'b1;

      for (int i = 0; i < 14; i++) begin
         tick(tbl[i].v, tbl[i].f, tbl[i].r, o_rdy, o_b, o_q, o_g);
         chk($sformatf("tbl%0d.busy", i), 32'(o_b), 32'(tbl[i].e_busy));
         chk($sformatf("tbl%0d.req", i), 32'(o_q), 32'(tbl[i].e_req));
         chk($sformatf("tbl%0d.ready", i), 32'(o_rdy), 32'(tbl[i].e_rdy));
         if (tbl[i].e_busy) chk($sformatf("tbl%0d.gid", i), 32'(o_g), 32'(tbl[i].e_gid));
      end

      // single requester held: back-to-back bursts with one idle cycle
      do_reset();
      repeat (35) step(4'b0001, 1'b0, 1'b1);
      chk("solo.gid0", qget(bg_a, 0), 0);
      chk("solo.start0", qget(bs_a, 0), 1);
      chk("solo.words0", qget(bw_a, 0), 16);
      chk("solo.gap", qget(bs_a, 1) - qget(bs_a, 0), 17);
      chk("solo.gid1", qget(bg_a, 1), 0);

      // all requesting: rotation 0,1,2,3,0
      do_reset();
      repeat (87) step(4'b1111, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("rr.gid%0d", i), qget(bg_a, i), i % NR);
         chk($sformatf("rr.words%0d", i), qget(bw_a, i), 16);
      end

      // FIFO full stall for 5 cycles after word 3
      do_reset();
      repeat (4) step(4'b0100, 1'b0, 1'b1);
      st = 0;
      repeat (5) begin
         tick(4'b0100, 1'b1, 1'b1, o_rdy, o_b, o_q, o_g);
         st = st + int'(o_q) + int'(o_rdy != 4'b0000);
      end
      repeat (14) step(4'b0100, 1'b0, 1'b1);
      chk("stall.quiet", st, 0);
      chk("stall.gid", qget(bg_a, 0), 2);
      chk("stall.words", qget(bw_a, 0), 16);
      chk("stall.cycles", qget(bc_a, 0), 21);

      // requester 1 drops after 7 words; next grant skips to 3
      do_reset();
      repeat (8) step(4'b0010, 1'b0, 1'b1);
      step(4'b1000, 1'b0, 1'b1);
      repeat (3) step(4'b1010, 1'b0, 1'b1);
      chk("drop.gid", qget(bg_a, 0), 1);
      chk("drop.words", qget(bw_a, 0), 7);
      chk("drop.cycles", qget(bc_a, 0), 8);
      chk("drop.next", qget(bg_a, 1), 3);

      // reset during word 9 of a burst to requester 3
      do_reset();
      repeat (9) step(4'b1000, 1'b0, 1'b1);
      step(4'b1111, 1'b0, 1'b0);
      tick(4'b1111, 1'b0, 1'b1, o_rdy, o_b, o_q, o_g);
      chk("rst.busy_after", 32'(o_b), 32'd0);
      chk("rst.req_after", 32'(o_q), 32'd0);
      repeat (2) step(4'b1111, 1'b0, 1'b1);
      chk("rst.gid", qget(bg_a, 0), 3);
      chk("rst.words", qget(bw_a, 0), 9);
      chk("rst.next", qget(bg_a, 1), 0);

      // single-word bursts alternate between 0 and 2
      do_reset();
      repeat (9) step(4'b0101, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("bl1.gid%0d", i), qget(bg_b, i), (i % 2) * 2);
         chk($sformatf("bl1.words%0d", i), qget(bw_b, i), 1);
         chk($sformatf("bl1.start%0d", i), qget(bs_b, i), 1 + 2 * i);
      end

      // random traffic against the model
      do_reset();
      repeat (800) begin
         logic [NR-1:0] v;
         for (int b = 0; b < NR; b++) v[b] = ($urandom_range(0, 9) < 8);
         step(v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 59) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
